// File: rtl/display_arbiter_if.sv
// Requester/display bundle for display_arbiter.
// slave = arbiter side, master = requester/display side.
interface display_arbiter_if #(
  parameter int N_SRC = 4
);
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]    req;
  logic [24*N_SRC-1:0] value;
  logic                freeze;
  logic [N_SRC-1:0]    gnt;
  logic [23:0]         disp_bin;
  logic [SW-1:0]       disp_src;
  logic                disp_valid;

  modport slave (
    input  req, value, freeze,
    output gnt, disp_bin, disp_src, disp_valid
  );

  modport master (
    output req, value, freeze,
    input  gnt, disp_bin, disp_src, disp_valid
  );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin time-sharing of the 6-digit display between N_SRC requesters.
// Optional DISPLAY_ARBITER_LIVE_EN: owner's value tracked live while shown.
module display_arbiter #(
  parameter int N_SRC        = 4,
  parameter int DWELL_CYCLES = 50000000,
  parameter int CNT_W        = 26
) (
  input logic             clk,
  input logic             rst_n,
  display_arbiter_if.slave bus
);
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHOW = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    last_q, last_d;
  logic [SW-1:0]    src_q, src_d;
  logic [23:0]      bin_q, bin_d;
  logic             valid_q, valid_d;
  logic [N_SRC-1:0] gnt_q, gnt_d;

  logic [23:0]   vals [N_SRC];
  logic          win_ok;
  logic [SW-1:0] win_idx;
  logic          expired;
  logic          capture;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      vals[i] = bus.value[24*i +: 24];
    end
  end

  // Rotating scan starting just after the last owner.
  always_comb begin
    int k;
    win_ok  = 1'b0;
    win_idx = '0;
    k       = 0;
    for (int i = 1; i <= N_SRC; i++) begin
      k = (int'(last_q) + i) % N_SRC;
      if (!win_ok && bus.req[SW'(k)]) begin
        win_ok  = 1'b1;
        win_idx = SW'(k);
      end
    end
  end

  assign expired = (cnt_q == '0);
  assign capture = win_ok &&
    ((state_q == IDLE) || (expired && !bus.freeze));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    src_d   = src_q;
    bin_d   = bin_q;
    valid_d = valid_q;
    gnt_d   = '0;

    case (state_q)
      SHOW: begin
`ifdef DISPLAY_ARBITER_LIVE_EN
        bin_d = vals[src_q];
`endif
        if (!expired) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!bus.freeze && !win_ok) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (capture) begin
      state_d = SHOW;
      cnt_d   = CNT_W'(DWELL_CYCLES - 1);
      last_d  = win_idx;
      src_d   = win_idx;
      bin_d   = vals[win_idx];
      valid_d = 1'b1;
      gnt_d   = N_SRC'(1) << win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= SW'(N_SRC - 1);
      src_q   <= '0;
      bin_q   <= '0;
      valid_q <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      src_q   <= src_d;
      bin_q   <= bin_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.disp_bin   = bin_q;
  assign bus.disp_src   = src_q;
  assign bus.disp_valid = valid_q;
endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Time-shares the single 6-digit seven-segment display between N_SRC requesters.
- Each requester offers a 24-bit hex value. The block grants sources round-robin and holds the granted value on the display for a fixed dwell time.
- disp_bin feeds the existing binary-to-display converter directly; disp_valid is used downstream to blank the digits.

Parameters:
- N_SRC, 4, number of requesters (2..8).
- DWELL_CYCLES, 50000000, clock cycles each grant is displayed (>=2).
- CNT_W, 26, dwell counter width; must satisfy 2^CNT_W > DWELL_CYCLES.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_SRC  per-source display request, level-sensitive.
- value  input  24*N_SRC  source i's value at bits [24*i+23:24*i].
- freeze  input  1  when high, the current owner keeps the display past dwell expiry.
- gnt  output  N_SRC  one-hot, single-cycle pulse on the cycle a source's value is captured.
- disp_bin  output  24  value to be displayed.
- disp_src  output  $clog2(N_SRC)  index of the current/last owner.
- disp_valid  output  1  high while in SHOW.

Behaviour:
- Reset (async, rst_n low): state=IDLE, gnt=0, disp_bin=0, disp_src=0, disp_valid=0, dwell counter=0, round-robin pointer last=N_SRC-1 (so source 0 wins first).
- States:
  - IDLE: display owned by nobody.
  - SHOW: a source's value is displayed.
- Arbitration function: scan from (last+1) mod N_SRC upward with wrap; the first index with req high wins. If only the previous owner requests, it wins again.
- IDLE -> SHOW, on the first edge where |req:
  - winner w captured: disp_bin<=value[w], disp_src<=w, last<=w, gnt[w]<=1 for exactly one cycle.
  - disp_valid<=1, counter<=DWELL_CYCLES-1.
  - Latency: req sampled at edge k gives gnt/disp_bin valid after edge k.
- SHOW, counter!=0: counter decrements each cycle. disp_bin is held (snapshot) regardless of req/value changes, including when the owner drops req.
- SHOW, counter==0, freeze=1: stay in SHOW, counter holds at 0, no gnt.
- SHOW, counter==0, freeze=0, |req: re-arbitrate in that same cycle with the same capture actions as IDLE->SHOW. There is no blank gap between owners.
- SHOW, counter==0, freeze=0, no req: go to IDLE. disp_valid<=0; disp_bin and disp_src retain their last values.
- freeze asserted in IDLE has no effect.
- freeze rising mid-dwell has no effect until the counter reaches 0.
- gnt is never multi-hot and never asserted in consecutive cycles unless DWELL_CYCLES would allow it (it cannot: minimum spacing is DWELL_CYCLES cycles).
- req bits for which no grant is issued are simply not latched; requesters must hold req until they see gnt.
- Reset mid-SHOW: outputs return to reset values immediately (asynchronously). After release, arbitration restarts from source 0.

Optional Feature:
- Macro: DISPLAY_ARBITER_LIVE_EN.
- Defined: while in SHOW, disp_bin<=value[disp_src] every cycle (live tracking of the owner's value, e.g. a running counter). The capture and gnt timing are unchanged. In IDLE, disp_bin still holds its last value.
- Undefined: snapshot behaviour as specified above.

Test Plan (N_SRC=4, DWELL_CYCLES=4):
- Reset then req=4'b0000 for 10 cycles -> disp_valid=0, disp_bin=24'h000000, gnt=0 throughout.
- req=4'b1111 with values 24'h111111/222222/333333/444444 held -> gnt pulses 0001,0010,0100,1000,0001 exactly 4 cycles apart; disp_bin tracks 111111, 222222, 333333, 444444; disp_valid stays high.
- req=4'b0100 only, value2=24'hABCDEF -> gnt=0100 every 4 cycles. Change value2 to 24'h123456 mid-dwell -> disp_bin stays ABCDEF until the next grant (snapshot). With DISPLAY_ARBITER_LIVE_EN defined -> disp_bin=123456 on the next cycle.
- Owner src1 granted, freeze=1 asserted before expiry, req=4'b1011 -> disp_src stays 1 with no gnt for 20 cycles. Release freeze -> next cycle gnt=1000.
- Single grant to src0, then req=0 -> after 4 cycles disp_valid=0; disp_bin retains src0's value and disp_src=0.
- rst_n pulled low mid-SHOW (asynchronous, between edges) -> disp_valid, gnt, disp_bin clear immediately. After release with req=4'b1010 -> first gnt=0010.
